// File: rtl/multiword_adder_sequencer_pkg.sv
// multiword_adder_sequencer_pkg: shared state encoding and word-index width helper
package multiword_adder_sequencer_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;
   function automatic int clog2_min1(input int v);
      return (v > 2) ? $clog2(v) : 1;
   endfunction
endpackage

// File: rtl/multiword_adder_sequencer_rca.sv
// Ripple_Carry_Adder_Nbit: purely combinational N-bit ripple-carry adder
module Ripple_Carry_Adder_Nbit #(
   parameter int N = 8
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic [N-1:0] s,
   output logic         cout
);
   always_comb begin : ripple
      logic c;
      s = '0;
      c = cin;
      for (int i = 0; i < N; i++) begin
         s[i] = a[i] ^ b[i] ^ c;
         c = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
      cout = c;
   end
endmodule

// File: rtl/multiword_adder_sequencer.sv
// multiword_adder_sequencer: multi-precision add/sub over one shared N-bit adder, one word per cycle LSW first
module multiword_adder_sequencer
   import multiword_adder_sequencer_pkg::*;
#(
   parameter int N     = 8,
   parameter int WORDS = 4
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   input  logic               sub,
   input  logic [N*WORDS-1:0] a,
   input  logic [N*WORDS-1:0] b,
   output logic               busy,
   output logic               done,
   output logic [N*WORDS-1:0] sum,
   output logic               cout,
   output logic               overflow
);
   localparam int W  = N * WORDS;
   localparam int IW = clog2_min1(WORDS);
   localparam logic [IW-1:0] LAST = IW'(WORDS - 1);
   state_e        state_q, state_d;
   logic [W-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
   logic [IW-1:0] idx_q, idx_d;
   logic          sub_q, sub_d, carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
   logic [N-1:0]  x, y, s;
   logic          co;
   assign x = a_q[int'(idx_q)*N +: N];
   assign y = b_q[int'(idx_q)*N +: N] ^ {N{sub_q}};
   Ripple_Carry_Adder_Nbit #(.N(N)) u_rca (
      .a   (x),
      .b   (y),
      .cin (carry_q),
      .s   (s),
      .cout(co)
   );
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sub_d   = sub_q;
      carry_d = carry_q;
      idx_d   = idx_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      if (state_q == IDLE && start) begin
         a_d     = a;
         b_d     = b;
         sub_d   = sub;
         carry_d = sub;
         idx_d   = '0;
         state_d = RUN;
      end else if (state_q == RUN) begin
         sum_d[int'(idx_q)*N +: N] = s;
         carry_d = co;
         idx_d   = idx_q + 1'b1;
         if (idx_q == LAST) begin
            state_d = DONE;
            cout_d  = co;
            ovf_d   = (x[N-1] == y[N-1]) && (s[N-1] != x[N-1]);
         end
      end else if (state_q == DONE) begin
         state_d = IDLE;
      end
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sub_q   <= 1'b0;
         carry_q <= 1'b0;
         idx_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sub_q   <= sub_d;
         carry_q <= carry_d;
         idx_q   <= idx_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end
   assign busy     = (state_q != IDLE);
   assign done     = (state_q == DONE);
   assign sum      = sum_q;
   assign cout     = cout_q;
   assign overflow = ovf_q;
endmodule
